// File: rtl/ub_affine_schedule_controller_if.sv
// Control, config and schedule bundle for the unified-buffer sequencer.
// master = stream control side, slave = schedule controller.
interface ub_affine_schedule_controller_if #(
  parameter int CW = 16,
  parameter int NL = 3
);
  logic          flush;
  logic          start;
  logic          stall;
  logic [CW-1:0] cfg_extent [NL-1:0];
  logic [CW-1:0] cfg_read_delay;
  logic          write_wen;
  logic [CW-1:0] write_ctrl_vars [NL-1:0];
  logic          read_ren;
  logic [CW-1:0] read_ctrl_vars [NL-1:0];
  logic          busy;
  logic          done;

  modport master (
    output flush,
    output start,
    output stall,
    output cfg_extent,
    output cfg_read_delay,
    input  write_wen,
    input  write_ctrl_vars,
    input  read_ren,
    input  read_ctrl_vars,
    input  busy,
    input  done
  );

  modport slave (
    input  flush,
    input  start,
    input  stall,
    input  cfg_extent,
    input  cfg_read_delay,
    output write_wen,
    output write_ctrl_vars,
    output read_ren,
    output read_ctrl_vars,
    output busy,
    output done
  );
endinterface

// File: rtl/ub_affine_schedule_controller.sv
// Write/read loop-nest sequencer for one unified buffer; the read
// schedule replays the write order after a programmable delay.
module ub_affine_schedule_controller #(
  parameter int CW = 16,
  parameter int NL = 3
) (
  input logic clk,
  input logic rst_n,
  ub_affine_schedule_controller_if.slave sif
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [CW-1:0] ext     [NL-1:0];
  logic [CW-1:0] wcv     [NL-1:0];
  logic [CW-1:0] rcv     [NL-1:0];
  logic [CW-1:0] wcv_nxt [NL-1:0];
  logic [CW-1:0] rcv_nxt [NL-1:0];
  logic [CW-1:0] dly;
  logic [CW-1:0] dcnt;
  logic          w_fin;
  logic          w_last;
  logic          r_last;
  logic          zero_ext;
  logic          accept;
  logic          run_go;
  logic          wr_go;
  logic          rd_go;

  always_comb begin
    zero_ext = 1'b0;
    for (int i = 0; i < NL; i++) begin
      if (sif.cfg_extent[i] == '0) zero_ext = 1'b1;
    end
  end

  assign accept = (state == IDLE) && sif.start;
  assign run_go = (state == RUN) && !sif.stall;
  assign wr_go  = run_go && !w_fin;
  assign rd_go  = run_go && (dcnt == dly);

  // Odometer step; the carry surviving every level marks the last index.
  always_comb begin : w_odo
    logic c;
    c = 1'b1;
    wcv_nxt = wcv;
    for (int i = NL - 1; i >= 0; i--) begin
      if (c) begin
        if (wcv[i] == ext[i] - 1'b1) begin
          wcv_nxt[i] = '0;
        end else begin
          wcv_nxt[i] = wcv[i] + 1'b1;
          c = 1'b0;
        end
      end
    end
    w_last = c;
  end

  always_comb begin : r_odo
    logic c;
    c = 1'b1;
    rcv_nxt = rcv;
    for (int i = NL - 1; i >= 0; i--) begin
      if (c) begin
        if (rcv[i] == ext[i] - 1'b1) begin
          rcv_nxt[i] = '0;
        end else begin
          rcv_nxt[i] = rcv[i] + 1'b1;
          c = 1'b0;
        end
      end
    end
    r_last = c;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (sif.start) state_nxt = zero_ext ? DONE : RUN;
      RUN:  if (rd_go && r_last) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else if (sif.flush) state <= IDLE;
    else state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NL; i++) begin
        ext[i] <= '0;
        wcv[i] <= '0;
        rcv[i] <= '0;
      end
      dly   <= '0;
      dcnt  <= '0;
      w_fin <= 1'b0;
    end else if (sif.flush) begin
      for (int i = 0; i < NL; i++) begin
        ext[i] <= '0;
        wcv[i] <= '0;
        rcv[i] <= '0;
      end
      dly   <= '0;
      dcnt  <= '0;
      w_fin <= 1'b0;
    end else if (accept) begin
      for (int i = 0; i < NL; i++) begin
        ext[i] <= sif.cfg_extent[i];
        wcv[i] <= '0;
        rcv[i] <= '0;
      end
      dly   <= sif.cfg_read_delay;
      dcnt  <= '0;
      w_fin <= 1'b0;
    end else begin
      // Final index is held rather than wrapped back to zero.
      if (wr_go) begin
        if (w_last) w_fin <= 1'b1;
        else wcv <= wcv_nxt;
      end
      if (rd_go) begin
        if (!r_last) rcv <= rcv_nxt;
      end else if (run_go) begin
        dcnt <= dcnt + 1'b1;
      end
    end
  end

  assign sif.write_wen       = wr_go;
  assign sif.write_ctrl_vars = wcv;
  assign sif.read_ren        = rd_go;
  assign sif.read_ctrl_vars  = rcv;
  assign sif.busy            = (state != IDLE);
  assign sif.done            = (state == DONE);

endmodule

// File: tb/tb_ub_affine_schedule_controller.sv
// Scoreboard bench: expected wen/ren/done events are queued at launch
// and a negedge monitor pops and compares them as the DUT emits them.
module tb_ub_affine_schedule_controller;
  localparam int CW = 16;
  localparam int NL = 3;

  typedef struct {
    int              cyc;
    logic [3*CW-1:0] v;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ub_affine_schedule_controller_if #(.CW(CW), .NL(NL)) bus();

  ub_affine_schedule_controller #(.CW(CW), .NL(NL)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sif(bus)
  );

  ev_t wq[$];
  ev_t rq[$];
  int  dq[$];
  int  tests = 0;
  int  fails = 0;
  int  cyc = 0;
  int  wcnt, rcnt;
  int  first_wen, first_ren, last_ren, done_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got event at cycle %0d, required none", nm, cyc);
  endtask

  function automatic logic [3*CW-1:0] vec(input int i, input int e1,
                                          input int e2);
    return {CW'(i / (e1 * e2)), CW'((i / e2) % e1), CW'(i % e2)};
  endfunction

  function automatic bit in_list(input int q[$], input int v);
    foreach (q[i]) if (q[i] == v) return 1'b1;
    return 1'b0;
  endfunction

  // Cycle walk of the expected schedule; k is the offset from the
  // accepting edge, stalled offsets are skipped entirely.
  task automatic model(input int e0, input int e1, input int e2,
                       input int d, input int s, input int st[$]);
    int n, w, r, dc, k;
    n = e0 * e1 * e2;
    w = 0; r = 0; dc = 0; k = 0;
    if (n == 0) begin
      dq.push_back(s + 1);
      return;
    end
    while (r < n) begin
      k++;
      if (!in_list(st, k)) begin
        if (w < n) begin
          wq.push_back('{cyc: s + k, v: vec(w, e1, e2)});
          w++;
        end
        if (dc == d) begin
          rq.push_back('{cyc: s + k, v: vec(r, e1, e2)});
          r++;
        end else begin
          dc++;
        end
      end
    end
    dq.push_back(s + k + 1);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.write_wen) begin
        ev_t e;
        wcnt++;
        if (first_wen < 0) first_wen = cyc;
        if (wq.size() == 0) bad("unexpected_wen");
        else begin
          e = wq.pop_front();
          chk("wen_cycle", cyc, e.cyc);
          chk("write_vars", {bus.write_ctrl_vars[0],
              bus.write_ctrl_vars[1], bus.write_ctrl_vars[2]}, e.v);
        end
      end
      if (bus.read_ren) begin
        ev_t e;
        rcnt++;
        if (first_ren < 0) first_ren = cyc;
        last_ren = cyc;
        if (rq.size() == 0) bad("unexpected_ren");
        else begin
          e = rq.pop_front();
          chk("ren_cycle", cyc, e.cyc);
          chk("read_vars", {bus.read_ctrl_vars[0],
              bus.read_ctrl_vars[1], bus.read_ctrl_vars[2]}, e.v);
        end
      end
      if (bus.done) begin
        done_cyc = cyc;
        if (dq.size() == 0) bad("unexpected_done");
        else chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input int e0, input int e1, input int e2,
                        input int d, input int st[$], output int s);
    wcnt = 0; rcnt = 0;
    first_wen = -1; first_ren = -1; last_ren = -1; done_cyc = -1;
    bus.cfg_extent[0] = CW'(e0);
    bus.cfg_extent[1] = CW'(e1);
    bus.cfg_extent[2] = CW'(e2);
    bus.cfg_read_delay = CW'(d);
    bus.start = 1'b1;
    s = cyc;
    model(e0, e1, e2, d, s, st);
    step();
    bus.start = 1'b0;
    bus.cfg_extent[0] = '1;
    bus.cfg_extent[1] = '1;
    bus.cfg_extent[2] = '1;
    bus.cfg_read_delay = '1;
  endtask

  task automatic run(input int e0, input int e1, input int e2,
                     input int d, input int st[$], input int rs,
                     output int s);
    int n;
    n = e0 * e1 * e2;
    launch(e0, e1, e2, d, st, s);
    for (int k = 0; k < 20000 && dq.size() != 0; k++) begin
      chk("busy_run", bus.busy, 1);
      bus.stall = in_list(st, cyc - s);
      bus.start = (rs > 0) && (cyc == s + rs);
      step();
    end
    bus.stall = 1'b0;
    bus.start = 1'b0;
    if (dq.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL timeout: got no done, required done");
      dq.delete();
    end
    chk("busy_idle", bus.busy, 0);
    chk("wen_count", wcnt, n);
    chk("ren_count", rcnt, n);
    chk("wq_left", wq.size(), 0);
    chk("rq_left", rq.size(), 0);
    wq.delete();
    rq.delete();
  endtask

  initial begin
    int none[$];
    int st3[$];
    int s;
    st3.push_back(3);
    st3.push_back(10);
    bus.flush = 1'b0;
    bus.start = 1'b0;
    bus.stall = 1'b0;
    bus.cfg_extent[0] = '0;
    bus.cfg_extent[1] = '0;
    bus.cfg_extent[2] = '0;
    bus.cfg_read_delay = '0;
    step();
    chk("rst_wen", bus.write_wen, 0);
    chk("rst_ren", bus.read_ren, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_wvars", {bus.write_ctrl_vars[0], bus.write_ctrl_vars[1],
        bus.write_ctrl_vars[2]}, 0);
    rst_n = 1'b1;
    step();

    run(1, 64, 64, 0, none, 0, s);
    chk("t1_first_wen", first_wen - s, 1);
    chk("t1_first_ren", first_ren - s, 1);
    chk("t1_done", done_cyc - s, 4097);

    run(2, 3, 4, 5, none, 0, s);
    chk("t2_first_ren", first_ren - s, 6);
    chk("t2_last_ren", last_ren - s, 29);
    chk("t2_done", done_cyc - s, 30);

    run(2, 3, 4, 5, st3, 0, s);
    chk("t3_first_ren", first_ren - s, 7);
    chk("t3_last_ren", last_ren - s, 31);
    chk("t3_done", done_cyc - s, 32);

    run(1, 0, 8, 0, none, 0, s);
    chk("t4_done", done_cyc - s, 1);

    launch(1, 64, 64, 0, none, s);
    for (int k = 0; k < 200 && cyc < s + 101; k++) step();
    chk("abort_at_iter100", {bus.write_ctrl_vars[0],
        bus.write_ctrl_vars[1], bus.write_ctrl_vars[2]}, vec(100, 64, 64));
    #2;
    rst_n = 1'b0;
    wq.delete();
    rq.delete();
    dq.delete();
    #1;
    chk("abort_wen", bus.write_wen, 0);
    chk("abort_ren", bus.read_ren, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_wvars", {bus.write_ctrl_vars[0], bus.write_ctrl_vars[1],
        bus.write_ctrl_vars[2]}, 0);
    chk("abort_rvars", {bus.read_ctrl_vars[0], bus.read_ctrl_vars[1],
        bus.read_ctrl_vars[2]}, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    run(2, 3, 4, 5, none, 0, s);
    chk("t5_done", done_cyc - s, 30);

    bus.cfg_extent[0] = 16'd2;
    bus.cfg_extent[1] = 16'd3;
    bus.cfg_extent[2] = 16'd4;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    step();
    bus.start = 1'b0;
    bus.flush = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("flush_idle", bus.busy, 0);
      step();
    end

    run(2, 3, 4, 5, none, 10, s);
    chk("t6_done", done_cyc - s, 30);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
